// File: rtl/retro_pinmux.sv
// Runtime pin multiplexer: per-pin function select over a small config bus, break-before-make
// turnaround on function changes, synchronised pad inputs. Define PINMUX_LOCK_EN for the lock register.
module retro_pinmux #(
    parameter int NUM_PIN     = 8,
    parameter int NUM_FUNC    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYC    = 2,
    localparam int FW         = $clog2(NUM_FUNC),
    localparam int AW         = $clog2(NUM_PIN + 1),
    localparam int NPF        = NUM_PIN * NUM_FUNC
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cfg_valid_i,
    input  logic              cfg_we_i,
    input  logic [AW-1:0]     cfg_addr_i,
    input  logic [FW-1:0]     cfg_wdata_i,
    output logic              cfg_ready_o,
    output logic [FW-1:0]     cfg_rdata_o,
    input  logic [NPF-1:0]    func_out_i,
    input  logic [NPF-1:0]    func_oe_i,
    output logic [NPF-1:0]    func_in_o,
    input  logic [NUM_PIN-1:0] pad_in_i,
    output logic [NUM_PIN-1:0] pad_out_o,
    output logic [NUM_PIN-1:0] pad_oe_o
);

    localparam int              CW         = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [CW-1:0]   CNT_RELOAD = CW'(TURN_CYC - 1);
    localparam logic [FW-1:0]   FUNC_MAX   = FW'(NUM_FUNC - 1);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_TURN   = 1'b1
    } pin_state_e;

    logic               cfg_ready_q, cfg_ready_d;
    logic [FW-1:0]      cfg_rdata_q, cfg_rdata_d;
    logic               cfg_fire;
    logic               addr_is_pin;
    logic               pin_wr_en;
    logic               locked;
    logic [FW-1:0]      wr_val;
    logic [NUM_PIN-1:0] wr_hit;
    logic [FW-1:0]      pend_view [NUM_PIN];

    logic [NUM_PIN-1:0] pad_out_q, pad_out_d;
    logic [NUM_PIN-1:0] pad_oe_q, pad_oe_d;
    logic [NUM_PIN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PIN-1:0] sync_d [SYNC_STAGES];
    logic [NUM_PIN-1:0] pad_sync;

    // A request is taken only while the ack flop is low, which gives one ack per two cycles at most.
    assign cfg_fire    = cfg_valid_i && !cfg_ready_q;
    assign addr_is_pin = 32'(cfg_addr_i) < NUM_PIN;
    assign wr_val      = (32'(cfg_wdata_i) >= NUM_FUNC) ? FUNC_MAX : cfg_wdata_i;
    assign pin_wr_en   = cfg_fire && cfg_we_i && addr_is_pin && !locked;

`ifdef PINMUX_LOCK_EN
    logic lock_q, lock_d;

    always_comb begin
        lock_d = lock_q;
        if (cfg_fire && cfg_we_i && (32'(cfg_addr_i) == NUM_PIN) && cfg_wdata_i[0]) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        cfg_ready_d = cfg_fire;
        cfg_rdata_d = '0;
        if (cfg_fire && !cfg_we_i) begin
            for (int p = 0; p < NUM_PIN; p++) begin
                if (32'(cfg_addr_i) == p) begin
                    cfg_rdata_d = pend_view[p];
                end
            end
`ifdef PINMUX_LOCK_EN
            if (32'(cfg_addr_i) == NUM_PIN) begin
                cfg_rdata_d = FW'(lock_q);
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_ready_q <= 1'b0;
            cfg_rdata_q <= '0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
            cfg_rdata_q <= cfg_rdata_d;
        end
    end

    always_comb begin
        sync_d[0] = pad_in_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign pad_sync = sync_q[SYNC_STAGES-1];

    for (genvar gi = 0; gi < NUM_PIN; gi++) begin : g_pin
        pin_state_e          state_q, state_d;
        logic [FW-1:0]       sel_q, sel_d;
        logic [FW-1:0]       pend_q, pend_d;
        logic [CW-1:0]       cnt_q, cnt_d;
        logic [NUM_FUNC-1:0] fout;
        logic [NUM_FUNC-1:0] foe;

        assign fout           = func_out_i[gi*NUM_FUNC +: NUM_FUNC];
        assign foe            = func_oe_i[gi*NUM_FUNC +: NUM_FUNC];
        assign wr_hit[gi]     = pin_wr_en && (32'(cfg_addr_i) == gi);
        assign pend_view[gi]  = pend_q;

        // A write during TURN restarts the window; writing back the live select cancels it.
        always_comb begin
            state_d = state_q;
            sel_d   = sel_q;
            pend_d  = pend_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_ACTIVE: begin
                    if (wr_hit[gi]) begin
                        pend_d = wr_val;
                        if (wr_val != sel_q) begin
                            cnt_d   = CNT_RELOAD;
                            state_d = ST_TURN;
                        end
                    end
                end
                ST_TURN: begin
                    if (wr_hit[gi]) begin
                        pend_d = wr_val;
                        cnt_d  = CNT_RELOAD;
                        if (wr_val == sel_q) begin
                            state_d = ST_ACTIVE;
                        end
                    end else if (cnt_q == '0) begin
                        sel_d   = pend_q;
                        state_d = ST_ACTIVE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_ACTIVE;
                end
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q <= ST_ACTIVE;
                sel_q   <= '0;
                pend_q  <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                sel_q   <= sel_d;
                pend_q  <= pend_d;
                cnt_q   <= cnt_d;
            end
        end

        assign pad_out_d[gi] = fout[sel_q];
        assign pad_oe_d[gi]  = (state_q == ST_ACTIVE) && foe[sel_q];

        // Only the selected function sees the pad; everything reads 0 while turning around.
        for (genvar gf = 0; gf < NUM_FUNC; gf++) begin : g_func
            assign func_in_o[gi*NUM_FUNC + gf] = (state_q == ST_ACTIVE) && (sel_q == FW'(gf))
                                                 && pad_sync[gi];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pad_out_q <= '0;
            pad_oe_q  <= '0;
        end else begin
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
        end
    end

    assign pad_out_o   = pad_out_q;
    assign pad_oe_o    = pad_oe_q;
    assign cfg_ready_o = cfg_ready_q;
    assign cfg_rdata_o = cfg_rdata_q;

endmodule

// File: tb/tb_retro_pinmux.sv
// Testbench for retro_pinmux: directed scenarios plus randomized traffic checked each cycle
// against a timestamp-based behavioural model of the pin selects, turnaround windows and lock.
module tb_retro_pinmux;

    localparam int NUM_PIN     = 8;
    localparam int NUM_FUNC    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TURN_CYC    = 2;
    localparam int FW          = $clog2(NUM_FUNC);
    localparam int AW          = $clog2(NUM_PIN + 1);
    localparam int NPF         = NUM_PIN * NUM_FUNC;

    logic               clk_i = 1'b0;
    logic               rst_n_i = 1'b1;
    logic               cfg_valid_i = 1'b0;
    logic               cfg_we_i = 1'b0;
    logic [AW-1:0]      cfg_addr_i = '0;
    logic [FW-1:0]      cfg_wdata_i = '0;
    logic               cfg_ready_o;
    logic [FW-1:0]      cfg_rdata_o;
    logic [NPF-1:0]     func_out_i = '0;
    logic [NPF-1:0]     func_oe_i = '1;
    logic [NPF-1:0]     func_in_o;
    logic [NUM_PIN-1:0] pad_in_i = '0;
    logic [NUM_PIN-1:0] pad_out_o;
    logic [NUM_PIN-1:0] pad_oe_o;

    retro_pinmux #(
        .NUM_PIN     (NUM_PIN),
        .NUM_FUNC    (NUM_FUNC),
        .SYNC_STAGES (SYNC_STAGES),
        .TURN_CYC    (TURN_CYC)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_rdata_o (cfg_rdata_o),
        .func_out_i  (func_out_i),
        .func_oe_i   (func_oe_i),
        .func_in_o   (func_in_o),
        .pad_in_i    (pad_in_i),
        .pad_out_o   (pad_out_o),
        .pad_oe_o    (pad_oe_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: live select, last written select, and the edge at which a pending switch commits.
    int                 sel_m [NUM_PIN];
    int                 pend_m [NUM_PIN];
    int                 turn_end_m [NUM_PIN];
    bit                 turning_m [NUM_PIN];
    bit                 ready_m;
    int                 rdata_m;
    bit                 lock_m;
    int                 edge_n = 0;
    logic [NUM_PIN-1:0] sync_m [$];
    logic [NUM_PIN-1:0] exp_out;
    logic [NUM_PIN-1:0] exp_oe;
    bit                 rand_io = 1'b0;

    task automatic m_reset();
        for (int p = 0; p < NUM_PIN; p++) begin
            sel_m[p] = 0;
            pend_m[p] = 0;
            turn_end_m[p] = 0;
            turning_m[p] = 1'b0;
        end
        ready_m = 1'b0;
        rdata_m = 0;
        lock_m  = 1'b0;
        exp_out = '0;
        exp_oe  = '0;
        sync_m.delete();
        for (int i = 0; i < SYNC_STAGES; i++) sync_m.push_back('0);
    endtask

    task automatic m_edge();
        bit fire;
        bit hit;
        int addr;
        int v;
        edge_n++;
        fire = cfg_valid_i && !ready_m;
        addr = int'(cfg_addr_i);
        v = (int'(cfg_wdata_i) >= NUM_FUNC) ? NUM_FUNC - 1 : int'(cfg_wdata_i);
        for (int p = 0; p < NUM_PIN; p++) begin
            exp_out[p] = func_out_i[p*NUM_FUNC + sel_m[p]];
            exp_oe[p]  = turning_m[p] ? 1'b0 : func_oe_i[p*NUM_FUNC + sel_m[p]];
        end
        rdata_m = 0;
        if (fire && !cfg_we_i) begin
            if (addr < NUM_PIN) rdata_m = pend_m[addr];
`ifdef PINMUX_LOCK_EN
            else if (addr == NUM_PIN) rdata_m = int'(lock_m);
`endif
        end
        for (int p = 0; p < NUM_PIN; p++) begin
            hit = fire && cfg_we_i && (addr == p) && !lock_m;
            if (hit) begin
                pend_m[p] = v;
                if (v == sel_m[p]) begin
                    turning_m[p] = 1'b0;
                end else begin
                    turning_m[p] = 1'b1;
                    turn_end_m[p] = edge_n + TURN_CYC;
                end
            end else if (turning_m[p] && edge_n == turn_end_m[p]) begin
                sel_m[p] = pend_m[p];
                turning_m[p] = 1'b0;
            end
        end
`ifdef PINMUX_LOCK_EN
        if (fire && cfg_we_i && addr == NUM_PIN && cfg_wdata_i[0]) lock_m = 1'b1;
`endif
        ready_m = fire;
        sync_m.push_front(pad_in_i);
        void'(sync_m.pop_back());
    endtask

    function automatic logic [NPF-1:0] exp_fin();
        logic [NPF-1:0]     r;
        logic [NUM_PIN-1:0] s;
        r = '0;
        s = sync_m[SYNC_STAGES-1];
        for (int p = 0; p < NUM_PIN; p++) begin
            if (!turning_m[p]) r[p*NUM_FUNC + sel_m[p]] = s[p];
        end
        return r;
    endfunction

    task automatic step();
        @(negedge clk_i);
        if (rand_io) begin
            func_out_i = NPF'({$urandom(), $urandom()});
            func_oe_i  = ~NPF'({$urandom() & $urandom(), $urandom() & $urandom()});
            pad_in_i   = NUM_PIN'($urandom());
        end
        @(posedge clk_i);
        m_edge();
        #1;
        check_eq("cfg_ready", 64'(cfg_ready_o), 64'(ready_m));
        check_eq("cfg_rdata", 64'(cfg_rdata_o), 64'(rdata_m));
        check_eq("pad_out", 64'(pad_out_o), 64'(exp_out));
        check_eq("pad_oe", 64'(pad_oe_o), 64'(exp_oe));
        check_eq("func_in", 64'(func_in_o), 64'(exp_fin()));
    endtask

    task automatic idle(input int n);
        cfg_valid_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic cfg_xact(input bit we, input int addr, input int data, output int rd);
        cfg_valid_i = 1'b1;
        cfg_we_i    = we;
        cfg_addr_i  = AW'(addr);
        cfg_wdata_i = FW'(data);
        for (int k = 0; k < 4; k++) begin
            step();
            if (ready_m) break;
        end
        rd = int'(cfg_rdata_o);
        $display("cfg %s addr=%0d data=%0d rdata=%0d", we ? "wr" : "rd", addr,
                 data & ((1 << FW) - 1), rd);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        cfg_valid_i = 1'b0;
        m_reset();
        #1;
        check_eq("rst_async_ready", 64'(cfg_ready_o), 64'd0);
        check_eq("rst_async_rdata", 64'(cfg_rdata_o), 64'd0);
        check_eq("rst_async_out", 64'(pad_out_o), 64'd0);
        check_eq("rst_async_oe", 64'(pad_oe_o), 64'd0);
        check_eq("rst_async_fin", 64'(func_in_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_hold_oe", 64'(pad_oe_o), 64'd0);
        rst_n_i = 1'b1;
    endtask

    initial begin
        int rd;
        int low;
        int addr;
        int data;
        bit we;

        func_out_i    = '0;
        func_out_i[0] = 1'b1;
        func_oe_i     = '1;
        do_reset();

        // Reset release: pin0 drives func0 one cycle later
        step();
        check_eq("t1_oe0", 64'(pad_oe_o[0]), 64'd1);
        check_eq("t1_out0", 64'(pad_out_o[0]), 64'd1);

        // Function switch pin3 -> 2
        func_out_i[14] = 1'b1;
        cfg_xact(1'b1, 3, 2, rd);
        check_eq("t2_ack", 64'(cfg_ready_o), 64'd1);
        idle(1);
        check_eq("t2_turn1_oe", 64'(pad_oe_o[3]), 64'd0);
        idle(1);
        check_eq("t2_turn2_oe", 64'(pad_oe_o[3]), 64'd0);
        idle(1);
        check_eq("t2_live_oe", 64'(pad_oe_o[3]), 64'd1);
        check_eq("t2_live_out", 64'(pad_out_o[3]), 64'd1);
        func_out_i[14] = 1'b0;
        idle(1);
        check_eq("t2_follow_out", 64'(pad_out_o[3]), 64'd0);
        cfg_xact(1'b0, 3, 0, rd);
        check_eq("t2_read", 64'(rd), 64'd2);

        // Restart mid-turnaround on pin1
        cfg_xact(1'b1, 1, 1, rd);
        idle(1);
        cfg_xact(1'b1, 1, 3, rd);
        cfg_valid_i = 1'b0;
        low = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (!pad_oe_o[1]) low++;
        end
        check_eq("t3_oe_low_ge_turn", 64'(low >= TURN_CYC), 64'd1);
        cfg_xact(1'b0, 1, 0, rd);
        check_eq("t3_read", 64'(rd), 64'd3);

        // Input routing on pin5, select 1
        cfg_xact(1'b1, 5, 1, rd);
        idle(3);
        pad_in_i[5] = 1'b1;
        idle(1);
        check_eq("t4_fin_lat1", 64'(func_in_o[5*NUM_FUNC +: NUM_FUNC]), 64'h0);
        idle(1);
        check_eq("t4_fin_rise", 64'(func_in_o[5*NUM_FUNC +: NUM_FUNC]), 64'h2);
        pad_in_i[5] = 1'b0;
        idle(1);
        check_eq("t4_fin_hold", 64'(func_in_o[5*NUM_FUNC +: NUM_FUNC]), 64'h2);
        idle(1);
        check_eq("t4_fin_fall", 64'(func_in_o[5*NUM_FUNC +: NUM_FUNC]), 64'h0);

        // Boundaries
`ifndef PINMUX_LOCK_EN
        cfg_xact(1'b1, NUM_PIN, 1, rd);
        cfg_xact(1'b0, NUM_PIN, 0, rd);
        check_eq("t5_lockaddr_read", 64'(rd), 64'd0);
`endif
        cfg_xact(1'b1, (1 << AW) - 1, 1, rd);
        cfg_xact(1'b0, (1 << AW) - 1, 0, rd);
        check_eq("t5_oor_read", 64'(rd), 64'd0);
        cfg_xact(1'b1, 0, 7, rd);
        cfg_xact(1'b0, 0, 0, rd);
        check_eq("t5_max_read", 64'(rd), 64'd3);
        cfg_xact(1'b1, 2, 0, rd);
        cfg_valid_i = 1'b0;
        low = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (!pad_oe_o[2]) low++;
        end
        check_eq("t5_same_sel_no_turn", 64'(low), 64'd0);

`ifdef PINMUX_LOCK_EN
        // Lock: pin writes ignored until reset
        cfg_xact(1'b1, NUM_PIN, 1, rd);
        cfg_xact(1'b1, 4, 1, rd);
        cfg_valid_i = 1'b0;
        low = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (!pad_oe_o[4]) low++;
        end
        check_eq("t6_locked_no_turn", 64'(low), 64'd0);
        cfg_xact(1'b0, 4, 0, rd);
        check_eq("t6_locked_pin_read", 64'(rd), 64'd0);
        cfg_xact(1'b0, NUM_PIN, 0, rd);
        check_eq("t6_lock_read", 64'(rd), 64'd1);
        do_reset();
        cfg_xact(1'b0, NUM_PIN, 0, rd);
        check_eq("t6_lock_cleared", 64'(rd), 64'd0);
        cfg_xact(1'b1, 4, 1, rd);
        cfg_xact(1'b0, 4, 0, rd);
        check_eq("t6_unlocked_write", 64'(rd), 64'd1);
`endif

        // Asynchronous reset in the middle of a turnaround
        rand_io = 1'b1;
        cfg_xact(1'b1, 6, 3, rd);
        idle(1);
        do_reset();
        cfg_xact(1'b0, 6, 0, rd);
        check_eq("rst_mid_turn_pend", 64'(rd), 64'd0);

        // Randomized traffic, including back-to-back requests
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 9) < 4) begin
                addr = ($urandom_range(0, 3) != 0) ? $urandom_range(0, NUM_PIN - 1)
                                                   : $urandom_range(0, (1 << AW) - 1);
                we   = ($urandom_range(0, 2) != 0);
                data = $urandom_range(0, (1 << FW) - 1);
`ifdef PINMUX_LOCK_EN
                if (we && addr == NUM_PIN) data = data & ~1;
`endif
                cfg_xact(we, addr, data, rd);
            end else begin
                idle(1);
            end
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
